zigbee_chip_spreader: RTL and testbench

//  802.15.4 O-QPSK spreader: takes 4-bit data symbols from the symbol DEMUX

---
 rtl/zigbee_pkg.sv | 19 +
 rtl/zigbee_pn_rom.sv | 23 ++
 rtl/zigbee_chip_spreader.sv | 137 +++++++++++++
 tb/tb_zigbee_chip_spreader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/zigbee_pkg.sv
// Shared constants and types for the 802.15.4 O-QPSK chip spreader.
// No logic; constants only.
// Imported by zigbee_pn_rom and zigbee_chip_spreader.
package zigbee_pkg;

  localparam int SYM_W         = 4;
  localparam int CHIPS_PER_SYM = 32;

  // Base PN sequence for symbol 0, chip c0 in the MSB.
  localparam logic [CHIPS_PER_SYM-1:0] PN0           = 32'hD9C3522E;
  // Symbols 8..15 invert the odd chips (c1, c3, ...) of symbols 0..7.
  localparam logic [CHIPS_PER_SYM-1:0] ODD_CHIP_MASK = 32'h55555555;

  typedef enum logic {
    IDLE   = 1'b0,
    SPREAD = 1'b1
  } state_t;

endpackage

// File: rtl/zigbee_pn_rom.sv
// Symbol-to-PN lookup: 4-bit symbol -> 32-chip sequence, c0 in the MSB.
// Latency: combinational.
// Backpressure: none; pure lookup.
module zigbee_pn_rom
  import zigbee_pkg::*;
(
  input  logic [SYM_W-1:0]         sym_i,
  output logic [CHIPS_PER_SYM-1:0] pn_o
);

  logic [4:0]               rot_amt;
  logic [5:0]               lsh_amt;
  logic [CHIPS_PER_SYM-1:0] rot;

  // Rotate PN0 right by 4 chips per symbol step; upper half also inverts odd chips.
  always_comb begin
    rot_amt = {sym_i[2:0], 2'b00};
    lsh_amt = 6'd32 - {1'b0, rot_amt};
    rot     = (PN0 >> rot_amt) | (PN0 << lsh_amt);
    pn_o    = sym_i[3] ? (rot ^ ODD_CHIP_MASK) : rot;
  end

endmodule

// File: rtl/zigbee_chip_spreader.sv
// O-QPSK spreader: accepts 4-bit symbols, emits their 32-chip PN sequences on inChipEn strobes.
// Latency: symbol accepted in IDLE at t is active at t+1; each strobe's chip(s) appear registered one cycle later.
// Backpressure: one ACTIVE plus one HOLD slot; outReady = !holdFull. Optional macro ZB_IQ_SPLIT_EN emits I/Q chip pairs.
module zigbee_chip_spreader
  import zigbee_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] inSymbol,
  input  logic             inValid,
  output logic             outReady,
  input  logic             inChipEn,
  output logic             outChipI,
  output logic             outChipQ,
  output logic             outChipValid,
  output logic             outSymDone,
  output logic             outBusy
);

`ifdef ZB_IQ_SPLIT_EN
  localparam logic [4:0] CNT_STEP = 5'd2;
  localparam logic [4:0] LAST_CNT = 5'd30;
`else
  localparam logic [4:0] CNT_STEP = 5'd1;
  localparam logic [4:0] LAST_CNT = 5'd31;
`endif

  state_t             state_q, state_d;
  logic [SYM_W-1:0]   active_q, active_d;
  logic [SYM_W-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               chip_i_q, chip_i_d;
  logic               chip_q_q, chip_q_d;
  logic               chip_vld_q, chip_vld_d;
  logic               sym_done_q, sym_done_d;

  logic               accept;
  logic               last_chip;
  logic [CHIPS_PER_SYM-1:0] pn;

  zigbee_pn_rom u_pn_rom (
    .sym_i (active_q),
    .pn_o  (pn)
  );

  // Ready is withheld during reset so nothing is taken in while state is being cleared.
  assign outReady  = ~hold_full_q & ~rst;
  assign accept    = inValid & outReady;
  assign last_chip = (cnt_q == LAST_CNT);

  // Next-state: symbol buffering, chip counter and registered chip outputs.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    chip_i_d    = chip_i_q;
    chip_q_d    = chip_q_q;
    chip_vld_d  = 1'b0;
    sym_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Strobes here are ignored; outputs keep their last chip.
        if (accept) begin
          active_d = inSymbol;
          cnt_d    = 5'd0;
          state_d  = SPREAD;
        end
      end
      SPREAD: begin
        // An accept on the last strobe with HOLD empty bypasses HOLD entirely.
        if (accept && !(inChipEn && last_chip)) begin
          hold_d      = inSymbol;
          hold_full_d = 1'b1;
        end
        if (inChipEn) begin
          chip_i_d   = pn[5'd31 - cnt_q];
`ifdef ZB_IQ_SPLIT_EN
          chip_q_d   = pn[5'd30 - cnt_q];
`else
          chip_q_d   = 1'b0;
`endif
          chip_vld_d = 1'b1;
          cnt_d      = cnt_q + CNT_STEP;
          if (last_chip) begin
            sym_done_d = 1'b1;
            cnt_d      = 5'd0;
            if (hold_full_q) begin
              active_d    = hold_q;
              hold_full_d = 1'b0;
            end else if (accept) begin
              active_d = inSymbol;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; pending symbols are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      active_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= 5'd0;
      chip_i_q    <= 1'b0;
      chip_q_q    <= 1'b0;
      chip_vld_q  <= 1'b0;
      sym_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      chip_i_q    <= chip_i_d;
      chip_q_q    <= chip_q_d;
      chip_vld_q  <= chip_vld_d;
      sym_done_q  <= sym_done_d;
    end
  end

  assign outChipI     = chip_i_q;
  assign outChipQ     = chip_q_q;
  assign outChipValid = chip_vld_q;
  assign outSymDone   = sym_done_q;
  assign outBusy      = (state_q == SPREAD) | hold_full_q;

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Testbench for zigbee_chip_spreader: directed symbols, scoreboard of expected chips.
// Driver pushes expected chips on each accept; a monitor pops and compares on every outChipValid.
// Works in serial mode and with ZB_IQ_SPLIT_EN defined.
module tb_zigbee_chip_spreader;

`ifdef ZB_IQ_SPLIT_EN
  localparam int SPS = 16;
`else
  localparam int SPS = 32;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] inSymbol;
  logic       inValid;
  logic       outReady;
  logic       inChipEn;
  logic       outChipI;
  logic       outChipQ;
  logic       outChipValid;
  logic       outSymDone;
  logic       outBusy;

  always #5 clk = ~clk;

  zigbee_chip_spreader dut (
    .clk          (clk),
    .rst          (rst),
    .inSymbol     (inSymbol),
    .inValid      (inValid),
    .outReady     (outReady),
    .inChipEn     (inChipEn),
    .outChipI     (outChipI),
    .outChipQ     (outChipQ),
    .outChipValid (outChipValid),
    .outSymDone   (outSymDone),
    .outBusy      (outBusy)
  );

  typedef struct packed {
    logic i;
    logic q;
    logic done;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   last_acc;

  // Hand-computed PN sequences for the symbols exercised here.
  function automatic logic [31:0] pn_ref(input int s);
    case (s)
      0:       return 32'hD9C3522E;
      1:       return 32'hED9C3522;
      2:       return 32'h2ED9C352;
      3:       return 32'h22ED9C35;
      4:       return 32'h522ED9C3;
      5:       return 32'h3522ED9C;
      7:       return 32'h9C3522ED;
      9:       return 32'hB8C96077;
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic void push_sym(input int s);
    logic [31:0] p;
    exp_t        e;
    p = pn_ref(s);
    for (int k = 0; k < SPS; k++) begin
`ifdef ZB_IQ_SPLIT_EN
      e.i = p[31-2*k];
      e.q = p[30-2*k];
`else
      e.i = p[31-k];
      e.q = 1'b0;
`endif
      e.done = (k == SPS - 1);
      sb.push_back(e);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, starting and ending at a negedge.
  task automatic step(input bit v, input logic [3:0] s, input bit en);
    inValid  = v;
    inSymbol = s;
    inChipEn = en;
    #1;
    last_acc = v && (outReady === 1'b1);
    if (last_acc) push_sym(int'(s));
    @(negedge clk);
  endtask

  // Monitor: every presented chip must match the head of the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (outChipValid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_chip", 32'(outChipValid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("chip", 32'({outChipI, outChipQ, outSymDone}), 32'({e.i, e.q, e.done}));
      end
    end else if (outSymDone === 1'b1) begin
      check("done_without_valid", 32'(outSymDone), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, nvld, accepted;
    bit drop_checked;
    logic [3:0] syms[3];

    rst = 1'b1; inValid = 1'b0; inSymbol = 4'd0; inChipEn = 1'b0;

    // 1. Reset held three cycles, then released.
    repeat (3) begin
      @(negedge clk);
      check("ready_in_rst", 32'(outReady), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(outReady), 32'd1);
    check("outs_after_rst", 32'({outChipI, outChipQ, outChipValid, outSymDone, outBusy}), 32'd0);
    @(negedge clk);

    // 2. Symbol 0 then a full symbol of strobes.
    step(1'b1, 4'd0, 1'b0);
    check("accept_sym0", 32'(last_acc), 32'd1);
    repeat (SPS) step(1'b0, 4'd0, 1'b1);
    repeat (2) step(1'b0, 4'd0, 1'b0);
    check("busy_idle_after_sym0", 32'(outBusy), 32'd0);
    check("sb_drain_sym0", 32'(sb.size()), 32'd0);

    // 3. Symbol 9 (odd-chip inverted sequence).
    step(1'b1, 4'd9, 1'b0);
    repeat (SPS) step(1'b0, 4'd0, 1'b1);
    repeat (2) step(1'b0, 4'd0, 1'b0);
    check("sb_drain_sym9", 32'(sb.size()), 32'd0);

    // 6. Strobes while IDLE, then accept coincident with a strobe.
    repeat (4) step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'd7, 1'b1);
    check("no_chip_on_accept", 32'(outChipValid), 32'd0);
    repeat (SPS) step(1'b0, 4'd0, 1'b1);
    repeat (2) step(1'b0, 4'd0, 1'b0);
    check("sb_drain_sym7", 32'(sb.size()), 32'd0);

    // 4. Back-to-back 3,4,5 with strobe every cycle.
    syms[0] = 4'd3; syms[1] = 4'd4; syms[2] = 4'd5;
    accepted = 0; first = -1; last = -1; nvld = 0; drop_checked = 1'b0;
    for (int c = 0; c < 3 * SPS + 6; c++) begin
      step(accepted < 3, (accepted < 3) ? syms[accepted] : 4'd0, 1'b1);
      if (last_acc) accepted++;
      if (accepted == 2 && !drop_checked) begin
        check("ready_drop", 32'(outReady), 32'd0);
        drop_checked = 1'b1;
      end
      if (outChipValid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        nvld++;
      end
    end
    inValid = 1'b0;
    check("b2b_accepts", 32'(accepted), 32'd3);
    check("b2b_chip_count", 32'(nvld), 32'(3 * SPS));
    check("b2b_no_gap", 32'(last - first + 1), 32'(nvld));
    check("sb_drain_b2b", 32'(sb.size()), 32'd0);

    // 5. Reset mid-symbol with HOLD full.
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    check("hold_full_ready", 32'(outReady), 32'd0);
    repeat (10) step(1'b0, 4'd0, 1'b1);
    rst = 1'b1; inValid = 1'b0; inChipEn = 1'b0;
    sb.delete();
    @(negedge clk);
    check("outs_on_rst", 32'({outChipI, outChipQ, outChipValid, outSymDone, outBusy}), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst2", 32'(outReady), 32'd1);
    @(negedge clk);
    nvld = 0;
    for (int c = 0; c < 2 * SPS + 4; c++) begin
      step(1'b0, 4'd0, 1'b1);
      if (outChipValid === 1'b1) nvld++;
    end
    check("no_chips_after_rst", 32'(nvld), 32'd0);
    step(1'b1, 4'd4, 1'b0);
    repeat (SPS) step(1'b0, 4'd0, 1'b1);
    repeat (2) step(1'b0, 4'd0, 1'b0);
    check("sb_drain_final", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
